// File: rtl/vga_capture.sv
// Sink-side VGA timing recovery: turns an active-low hsync/vsync pair plus 1-bit rgb into
// per-pixel (x, y, colour), but only while the incoming timing matches the configured mode.
module vga_capture #(
    parameter int ACTIVE_H_VIDEO = 640,
    parameter int ACTIVE_V_VIDEO = 480,
    parameter int H_PULSE        = 48,
    parameter int HBP            = 100,
    parameter int V_PULSE        = 3,
    parameter int VBP            = 25,
    parameter int H_PIXELS       = 820,
    parameter int V_LINES        = 509
) (
    input  logic       clk_36MHz,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       red,
    input  logic       green,
    input  logic       blue,
    output logic       pix_valid,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [2:0] pix_rgb,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] err_count,
    output logic [1:0] state_dbg
);

    // Handshake: pix_valid qualifies x/y/pix_rgb for exactly one cycle; there is no ready,
    // the sink must take every valid pixel. x/y/pix_rgb are held at 0 whenever pix_valid is 0.

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [9:0]  H_OFF       = 10'(H_PULSE + HBP + 1);
    localparam logic [9:0]  H_END       = 10'(H_PULSE + HBP + 1 + ACTIVE_H_VIDEO);
    localparam logic [9:0]  V_OFF       = 10'(V_PULSE + VBP + 1);
    localparam logic [9:0]  V_END       = 10'(V_PULSE + VBP + 1 + ACTIVE_V_VIDEO);
    localparam logic [10:0] LINE_LEN    = 11'(H_PIXELS);
    localparam logic [9:0]  FRAME_LINES = 10'(V_LINES);
    localparam logic [9:0]  CNT_MAX     = 10'd1023;

    logic       hs_s1, hs_s2, vs_s1, vs_s2;
    logic [2:0] rgb_s1;
    logic [9:0] h_cnt, v_cnt;
    logic       first_h_done;
    state_t     state;

    logic h_edge, v_edge, h_sat, len_bad, active;
    logic measure_fail, lock_gain, locked_fail, lock_next, show;

    assign h_edge  = !hs_s1 && hs_s2;
    assign v_edge  = !vs_s1 && vs_s2;
    assign h_sat   = (h_cnt == CNT_MAX);
    assign len_bad = h_edge && (({1'b0, h_cnt} + 11'd1) != LINE_LEN);
    assign active  = (h_cnt >= H_OFF) && (h_cnt < H_END) &&
                     (v_cnt >= V_OFF) && (v_cnt < V_END);

    // The very first hsync edge after reset closes a line of unknown length, so it is not judged.
    assign measure_fail = (len_bad && first_h_done) || h_sat;
    assign lock_gain    = !measure_fail && v_edge && (v_cnt == FRAME_LINES);
    assign locked_fail  = len_bad || h_sat || (v_cnt > FRAME_LINES) ||
                          (v_edge && (v_cnt != FRAME_LINES));
    assign lock_next    = ((state == LOCKED) && !locked_fail) ||
                          ((state == MEASURE) && lock_gain);
    assign show         = lock_next && active;
    assign state_dbg    = state;

    always_ff @(posedge clk_36MHz or posedge rst) begin
        if (rst) begin
            hs_s1  <= 1'b1;
            hs_s2  <= 1'b1;
            vs_s1  <= 1'b1;
            vs_s2  <= 1'b1;
            rgb_s1 <= 3'd0;
        end else begin
            hs_s1  <= hsync;
            hs_s2  <= hs_s1;
            vs_s1  <= vsync;
            vs_s2  <= vs_s1;
            rgb_s1 <= {red, green, blue};
        end
    end

    always_ff @(posedge clk_36MHz or posedge rst) begin
        if (rst) begin
            h_cnt        <= CNT_MAX;
            v_cnt        <= 10'd0;
            first_h_done <= 1'b0;
        end else begin
            if (h_edge) begin
                h_cnt        <= 10'd0;
                first_h_done <= 1'b1;
            end else if (!h_sat) begin
                h_cnt <= h_cnt + 10'd1;
            end
            // A vsync edge landing on an hsync edge starts the frame's first line at 1.
            if (v_edge && h_edge)
                v_cnt <= 10'd1;
            else if (v_edge)
                v_cnt <= 10'd0;
            else if (h_edge && (v_cnt != CNT_MAX))
                v_cnt <= v_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk_36MHz or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            err_count <= 8'd0;
        end else begin
            locked <= lock_next;
            case (state)
                SEARCH: begin
                    if (v_edge)
                        state <= MEASURE;
                end
                MEASURE: begin
                    if (measure_fail)
                        state <= SEARCH;
                    else if (lock_gain)
                        state <= LOCKED;
                end
                LOCKED: begin
                    if (locked_fail) begin
                        state <= SEARCH;
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_36MHz or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            pix_valid   <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
            pix_rgb     <= 3'd0;
        end else begin
            frame_start <= v_edge;
            pix_valid   <= show;
            if (show) begin
                x       <= h_cnt - H_OFF;
                y       <= v_cnt - V_OFF;
                pix_rgb <= rgb_s1;
            end else begin
                x       <= 10'd0;
                y       <= 10'd0;
                pix_rgb <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture in a shrunken video mode: a frame-level generator/model pushes expected
// pixels and frame-start lock status into queues; a monitor pops and compares on DUT outputs.
module tb_vga_capture;

    localparam int ACT_H = 8;
    localparam int ACT_V = 4;
    localparam int HP    = 2;
    localparam int HB    = 3;
    localparam int VP    = 1;
    localparam int VB    = 2;
    localparam int HPIX  = 20;
    localparam int VLIN  = 10;
    // Pixel x=0 is driven HP+HB+2 cycles after the hsync fall; row 0 is line VP+VB of the frame.
    localparam int PIX_OFS = HP + HB + 2;
    localparam int ROW_OFS = VP + VB;

    logic       clk_36MHz;
    logic       rst;
    logic       hsync, vsync, red, green, blue;
    logic       pix_valid;
    logic [9:0] x, y;
    logic [2:0] pix_rgb;
    logic       frame_start, locked;
    logic [7:0] err_count;
    logic [1:0] state_dbg;

    vga_capture #(
        .ACTIVE_H_VIDEO(ACT_H), .ACTIVE_V_VIDEO(ACT_V), .H_PULSE(HP), .HBP(HB),
        .V_PULSE(VP), .VBP(VB), .H_PIXELS(HPIX), .V_LINES(VLIN)
    ) dut (
        .clk_36MHz(clk_36MHz), .rst(rst), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .pix_valid(pix_valid), .x(x), .y(y),
        .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
        .err_count(err_count), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk_36MHz = 1'b0;
    always #5 clk_36MHz = ~clk_36MHz;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [22:0] exp_q[$];
    logic [8:0]  exp_fs_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int rst_hold = 0;

    bit m_bounded = 0;
    bit m_clean   = 0;
    bit m_locked  = 0;
    int m_err     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level reference: a frame start locks iff the frame it closes began at a seen vsync
    // and ran without any timing fault.
    task automatic model_frame_start();
        m_locked  = m_bounded && m_clean;
        m_bounded = 1'b1;
        m_clean   = 1'b1;
        exp_fs_q.push_back({m_locked, 8'(m_err)});
    endtask

    task automatic model_fault();
        if (m_locked && m_err < 255)
            m_err++;
        m_locked = 1'b0;
        m_clean  = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic hs, input logic vs, input logic [2:0] c);
        hsync = hs;
        vsync = vs;
        {red, green, blue} = c;
        @(posedge clk_36MHz);
        #1;
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0)
                rst = 1'b0;
        end
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b1;
        rst_hold = 3;
        #1;
        check("rst_async_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_async_xy_rgb", 32'({x, y, pix_rgb}), 32'd0);
        check("rst_async_frame_start", 32'(frame_start), 32'd0);
        check("rst_async_locked", 32'(locked), 32'd0);
        check("rst_async_err_count", 32'(err_count), 32'd0);
        m_bounded = 1'b0;
        m_locked  = 1'b0;
        m_err     = 0;
    endtask

    task automatic drive_frame(input int nlines, input int short_line, input int rst_line,
                               input bit stall);
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == short_line) ? HPIX - 1 : HPIX;
            if (l == 0)
                model_frame_start();
            if (l == VLIN)
                model_fault();
            for (int p = 0; p < len; p++) begin
                logic [2:0] c;
                int px, py;
                c  = 3'($urandom_range(0, 7));
                px = p - PIX_OFS;
                py = l - ROW_OFS;
                if (l == rst_line && p == 10)
                    do_reset();
                if (m_locked && px >= 0 && px < ACT_H && py >= 0 && py < ACT_V)
                    exp_q.push_back({10'(px), 10'(py), c});
                drive(p >= HP, l >= VP, c);
            end
            if (l == short_line)
                model_fault();
        end
        if (stall) begin
            model_fault();
            repeat (2000) drive(1'b1, 1'b1, 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic clean_frames(input int n);
        for (int i = 0; i < n; i++)
            drive_frame(VLIN, -1, -1, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_36MHz) begin
        if (pix_valid) begin
            check("pix_expected_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("pix_xy_rgb", 32'({x, y, pix_rgb}), 32'(exp_q.pop_front()));
        end else begin
            check("idle_xy_rgb_zero", 32'({x, y, pix_rgb}), 32'd0);
        end
        if (frame_start) begin
            check("fs_expected_pending", 32'(exp_fs_q.size() != 0), 32'd1);
            if (exp_fs_q.size() != 0)
                check("fs_locked_err", 32'({locked, err_count}), 32'(exp_fs_q.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        red   = 1'b0;
        green = 1'b0;
        blue  = 1'b0;
        repeat (3) @(posedge clk_36MHz);
        #1;
        check("reset_pix_valid", 32'(pix_valid), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        check("reset_frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;
        repeat (5) drive(1'b1, 1'b1, 3'($urandom_range(0, 7)));

        clean_frames(3);
        drive_frame(VLIN, $urandom_range(ROW_OFS, ROW_OFS + ACT_V - 1), -1, 1'b0);
        clean_frames(2 + $urandom_range(0, 1));
        drive_frame(VLIN + 1, -1, -1, 1'b0);
        clean_frames(2 + $urandom_range(0, 1));
        drive_frame(VLIN, -1, -1, 1'b1);
        clean_frames(2 + $urandom_range(0, 1));
        drive_frame(VLIN, -1, 8, 1'b0);
        clean_frames(3);
        repeat (10) drive(1'b1, 1'b1, 3'($urandom_range(0, 7)));

        check("end_pixels_drained", 32'(exp_q.size()), 32'd0);
        check("end_frame_starts_drained", 32'(exp_fs_q.size()), 32'd0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
# vga_capture

Sink-side companion to the VGA timing generator: watches an active-low hsync/vsync pair plus 1-bit-per-channel colour in the 36 MHz domain and recovers pixel coordinates. It reports, per cycle, whether the current pixel is an active video pixel, its (x, y) position and its colour. It verifies the incoming timing against the configured mode and only flags pixels valid while locked. It is used for loop-back testing and to feed captured frames into the Game of Life cell memory.

## Interface
Parameters (defaults match the team's 640x480 mode):
- ACTIVE_H_VIDEO, 640: active pixels per line
- ACTIVE_V_VIDEO, 480: active lines per frame
- H_PULSE, 48: hsync low length (cycles)
- HBP, 100: horizontal back porch
- V_PULSE, 3: vsync low length (lines)
- VBP, 25: vertical back porch
- H_PIXELS, 820: expected cycles per line
- V_LINES, 509: expected lines per frame

Ports:
- clk_36MHz  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- red, green, blue  in  1 each  pixel colour
- pix_valid  out  1  active, locked pixel on x/y/pix_rgb this cycle
- x  out  10  column 0..ACTIVE_H_VIDEO-1
- y  out  10  row 0..ACTIVE_V_VIDEO-1
- pix_rgb  out  3  {red, green, blue} for this pixel
- frame_start  out  1  one-cycle pulse at each detected vsync falling edge
- locked  out  1  timing matches parameters
- err_count  out  8  saturating count of lock losses

## Operation
- Input stage: hsync, vsync and rgb are registered once (s1), then hsync and vsync a second time (s2). A falling edge means s1 == 0 and s2 == 1. Colour travels alongside s1, so colour and sync stay aligned.
- h_cnt (10 bit): cleared to 0 on an hsync edge, otherwise increments, saturating at 1023. line_len = h_cnt + 1 is captured at each hsync edge.
- v_cnt (10 bit): increments on each hsync edge and clears on a vsync edge. If both edges occur in the same cycle, v_cnt becomes 1.
- Active window:
  - H_OFF = H_PULSE + HBP + 1 and V_OFF = V_PULSE + VBP + 1.
  - A pixel is active when h_cnt is in [H_OFF, H_OFF+ACTIVE_H_VIDEO) and v_cnt is in [V_OFF, V_OFF+ACTIVE_V_VIDEO).
  - x = h_cnt - H_OFF, y = v_cnt - V_OFF.
  - This accounts for the generator's registered colour arriving one cycle after its counter.
- Lock FSM, states SEARCH, MEASURE, LOCKED:
  - SEARCH: on a vsync edge, go to MEASURE.
  - MEASURE:
    - Any hsync edge whose line_len != H_PIXELS goes to SEARCH. The first hsync edge after reset is exempt.
    - h_cnt reaching 1023 goes to SEARCH.
    - On a vsync edge: if v_cnt == V_LINES go to LOCKED, otherwise stay in MEASURE and restart the frame.
  - LOCKED: any of the following goes to SEARCH and increments err_count (saturating at 255):
    - line_len mismatch
    - h_cnt saturation
    - v_cnt > V_LINES
    - a vsync edge with v_cnt != V_LINES
- locked = (state == LOCKED).
- pix_valid = locked and active. When pix_valid is 0, x, y and pix_rgb are driven to 0.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - all sync registers to 1 and colour to 0
  - h_cnt = 1023, v_cnt = 0
  - state SEARCH
  - outputs all 0
- Latency: the rgb present on the input pins at cycle t appears on pix_rgb at t+2, with x/y/pix_valid aligned to it. All outputs are registered.
- frame_start asserts 2 cycles after the vsync pin first reads 0. It fires in every state.
- locked rises in the same cycle as the frame_start that closes the first fully conforming frame. The earliest lock is the second vsync edge after reset.
- On a loss of lock, locked and pix_valid fall on the output cycle following the offending edge or condition, never mid-pixel-stream partially.
- Reset mid-frame: the block re-enters SEARCH and no pix_valid is produced until a full conforming frame has been measured.

## Test plan
- Default vga_controller drives the bench with rgb = x[2:0]. Response:
  - locked at the 2nd frame_start
  - exactly 307200 pix_valid cycles per locked frame
  - at every pix_valid, pix_rgb == x[2:0] and (x, y) matches the generator's coordinates, the first being (0, 0), the last (639, 479)
- Frame boundaries: frame_start period = 820*509 = 417380 cycles. Between frame_starts, x wraps 639 -> 0 and y increments by 1 on each new line.
- One line shortened to 819 cycles while locked:
  - locked falls and err_count = 1
  - no pix_valid until 2 frame_starts later, when relock occurs
- hsync held high for 2000 cycles: h_cnt saturates, state goes to SEARCH, err_count increments once (not per cycle).
- A frame with 510 lines while locked: lock is lost at v_cnt = 510, err_count increments, and relock follows after one conforming frame.
- Assert rst for 3 cycles mid-line:
  - outputs 0 immediately, asynchronously
  - err_count = 0 and locked = 0
  - relock at the 2nd subsequent frame_start
